// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use stalls, branch
// flushes, data-memory wait holds with timeout, EX forwarding selects and
// saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             CntClear,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic       timeout_c;
  logic       mem_hold_c;
  logic       lw_stall_c;
  logic       flush_evt_c;
  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;

  // Hazard detection terms: memory hold, timeout and load-use.
  always_comb begin
    timeout_c  = (state_q == MEMWAIT) & ~MemReadyM & TIMEOUT_EN &
                 (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));
    mem_hold_c = (state_q == RUN) ? (MemReqM & ~MemReadyM)
                                  : (~MemReadyM & ~timeout_c);
    lw_stall_c = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  end

  // Forwarding selects; MEM result is newer so it beats WB.
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (RegWriteM && (RdM == Rs1E) && (Rs1E != 5'd0))      fwd_a_c = 2'b10;
    else if (RegWriteW && (RdW == Rs1E) && (Rs1E != 5'd0)) fwd_a_c = 2'b01;
    if (RegWriteM && (RdM == Rs2E) && (Rs2E != 5'd0))      fwd_b_c = 2'b10;
    else if (RegWriteW && (RdW == Rs2E) && (Rs2E != 5'd0)) fwd_b_c = 2'b01;
  end

  // Same-cycle pipeline controls, priority memory hold > branch > load-use.
  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    flush_evt_c = 1'b0;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_a_c;
      ForwardBE = fwd_b_c;
      if (mem_hold_c) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD      = 1'b1;
        FlushE      = 1'b1;
        flush_evt_c = 1'b1;
      end else if (lw_stall_c) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Next state for memory-wait FSM, sticky error and counters.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_d    = MEMWAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEMWAIT: begin
        if (MemReadyM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (timeout_c) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (CntClear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && (stall_cnt_q != '1))      stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_evt_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned T_OUT = 4;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = 15;

  localparam logic [10:0] C_RST  = 11'b0000_111_00_00;
  localparam logic [10:0] C_HOLD = 11'b1111_001_00_00;
  localparam logic [10:0] C_BR   = 11'b0000_110_00_00;
  localparam logic [10:0] C_LW   = 11'b1100_010_00_00;
  localparam logic [10:0] C_IDLE = 11'b0000_000_00_00;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, CntClear;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic MemErr;
  logic [CW-1:0] StallCount, FlushCount;
  logic [10:0] ctrl;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: cycles the current access has been pending.
  int m_pend = 0;
  bit m_err  = 1'b0;
  int m_sc   = 0;
  int m_fc   = 0;

  always #5 clk = ~clk;

  assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CntClear(CntClear),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs != 5'd0 && RegWriteM && RdM == rs) return 2'b10;
    if (rs != 5'd0 && RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_hold();
    if (m_pend == 0) return MemReqM && !MemReadyM;
    return !MemReadyM && (m_pend != int'(T_OUT));
  endfunction

  function automatic logic [10:0] ref_ctrl();
    logic [3:0] fw;
    bit lw;
    if (!reset) return C_RST;
    fw = {ref_fwd(Rs1E), ref_fwd(Rs2E)};
    lw = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    if (ref_hold()) return {7'b1111_001, fw};
    if (PCSrcE)     return {7'b0000_110, fw};
    if (lw)         return {7'b1100_010, fw};
    return {7'b0, fw};
  endfunction

  task automatic model_update();
    logic [10:0] c;
    bit hold;
    c    = ref_ctrl();
    hold = ref_hold();
    if (!reset) begin
      m_pend = 0; m_err = 1'b0; m_sc = 0; m_fc = 0;
      return;
    end
    if (CntClear) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (c[10] && m_sc < CMAX) m_sc++;
      if (!hold && PCSrcE && m_fc < CMAX) m_fc++;
    end
    if (m_pend == 0) begin
      if (MemReqM && !MemReadyM) m_pend = 1;
    end else if (MemReadyM) begin
      m_pend = 0;
    end else if (m_pend == int'(T_OUT)) begin
      m_pend = 0; m_err = 1'b1;
    end else begin
      m_pend++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b1;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0; CntClear = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    Rs1E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1; PCSrcE = 1'b1; MemReqM = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_RST) begin n_err++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_RST); end
    tick();
    #1;
    n_vec++;
    if ({MemErr, StallCount, FlushCount} !== 9'd0) begin
      n_err++; $display("FAIL reset_regs err=%b sc=%0d fc=%0d exp 0", MemErr, StallCount, FlushCount);
    end
    idle();
  endtask

  task automatic test_forwarding();
    do_reset();
    Rs1E = 5'd3; RdM = 5'd3; RdW = 5'd3; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs2E = 5'd9;
    #1;
    n_vec++;
    if (ctrl !== 11'b0000_000_10_00) begin n_err++; $display("FAIL fwd_mem_wins got=%b exp=%b", ctrl, 11'b0000_000_10_00); end
    Rs1E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1; Rs2E = 5'd4; RdW = 5'd4; RegWriteW = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== 11'b0000_000_00_01) begin n_err++; $display("FAIL fwd_x0_wb got=%b exp=%b", ctrl, 11'b0000_000_00_01); end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd1;
    #1;
    n_vec++;
    if (ctrl !== C_LW) begin n_err++; $display("FAIL lw_stall got=%b exp=%b", ctrl, C_LW); end
    tick();
    idle();
    RdM = 5'd5; RegWriteM = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_IDLE) begin n_err++; $display("FAIL lw_bubble got=%b exp=%b", ctrl, C_IDLE); end
    tick();
    idle();
    RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd1;
    #1;
    n_vec++;
    if (ctrl !== 11'b0000_000_01_00) begin n_err++; $display("FAIL lw_fwd_wb got=%b exp=%b", ctrl, 11'b0000_000_01_00); end
    n_vec++;
    if (StallCount !== 4'd1) begin n_err++; $display("FAIL lw_stallcount got=%0d exp=1", StallCount); end
    tick();
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    #1;
    n_vec++;
    if (ctrl !== C_BR) begin n_err++; $display("FAIL branch_over_lw got=%b exp=%b", ctrl, C_BR); end
    tick();
    idle();
    #1;
    n_vec++;
    if ({FlushCount, StallCount} !== {4'd1, 4'd0}) begin
      n_err++; $display("FAIL branch_counts fc=%0d sc=%0d exp fc=1 sc=0", FlushCount, StallCount);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #1;
    n_vec++;
    if (ctrl !== C_IDLE) begin n_err++; $display("FAIL mem_zero_wait got=%b exp=%b", ctrl, C_IDLE); end
    tick();
    for (int i = 0; i < 4; i++) begin
      MemReqM = 1'b1; MemReadyM = (i == 3); PCSrcE = (i < 3);
      #1;
      n_vec++;
      if (ctrl !== ((i < 3) ? C_HOLD : C_IDLE)) begin
        n_err++; $display("FAIL mem_wait[%0d] got=%b exp=%b", i, ctrl, (i < 3) ? C_HOLD : C_IDLE);
      end
      tick();
    end
    idle();
    #1;
    n_vec++;
    if ({MemErr, StallCount, FlushCount} !== {1'b0, 4'd3, 4'd0}) begin
      n_err++; $display("FAIL mem_wait_regs err=%b sc=%0d fc=%0d exp err=0 sc=3 fc=0", MemErr, StallCount, FlushCount);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      MemReqM = 1'b1; MemReadyM = 1'b0;
      #1;
      n_vec++;
      if (ctrl !== ((i < 4) ? C_HOLD : C_IDLE)) begin
        n_err++; $display("FAIL timeout[%0d] got=%b exp=%b", i, ctrl, (i < 4) ? C_HOLD : C_IDLE);
      end
      tick();
    end
    MemReqM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({MemErr, StallCount} !== {1'b1, 4'd4}) begin
        n_err++; $display("FAIL timeout_err[%0d] err=%b sc=%0d exp err=1 sc=4", i, MemErr, StallCount);
      end
      tick();
    end
    MemReqM = 1'b1;
    tick();
    tick();
    #1;
    n_vec++;
    if (ctrl !== C_HOLD) begin n_err++; $display("FAIL midwait_hold got=%b exp=%b", ctrl, C_HOLD); end
    reset = 1'b0;
    #1;
    n_vec++;
    if (ctrl !== C_RST) begin n_err++; $display("FAIL midwait_rst got=%b exp=%b", ctrl, C_RST); end
    tick();
    idle();
    #1;
    n_vec++;
    if ({ctrl, MemErr, StallCount, FlushCount} !== {C_IDLE, 1'b0, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL midwait_after ctrl=%b err=%b sc=%0d fc=%0d exp idle/0", ctrl, MemErr, StallCount, FlushCount);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ResultSrcE0 = 1'b1; RdE = 5'd2; Rs1D = 5'd2;
    repeat (20) tick();
    #1;
    n_vec++;
    if (StallCount !== 4'd15) begin n_err++; $display("FAIL stall_sat got=%0d exp=15", StallCount); end
    CntClear = 1'b1;
    tick();
    CntClear = 1'b0;
    #1;
    n_vec++;
    if (StallCount !== 4'd0) begin n_err++; $display("FAIL clear_wins got=%0d exp=0", StallCount); end
    tick();
    ResultSrcE0 = 1'b0; PCSrcE = 1'b1;
    repeat (18) tick();
    #1;
    n_vec++;
    if ({FlushCount, StallCount} !== {4'd15, 4'd1}) begin
      n_err++; $display("FAIL flush_sat fc=%0d sc=%0d exp fc=15 sc=1", FlushCount, StallCount);
    end
    idle();
  endtask

  task automatic test_random();
    logic [10:0] ec;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 59) != 0);
      Rs1D        = 5'($urandom_range(0, 3));
      Rs2D        = 5'($urandom_range(0, 3));
      Rs1E        = 5'($urandom_range(0, 3));
      Rs2E        = 5'($urandom_range(0, 3));
      RdE         = 5'($urandom_range(0, 3));
      RdM         = 5'($urandom_range(0, 3));
      RdW         = 5'($urandom_range(0, 3));
      ResultSrcE0 = ($urandom_range(0, 2) == 0);
      RegWriteM   = ($urandom_range(0, 1) == 0);
      RegWriteW   = ($urandom_range(0, 1) == 0);
      PCSrcE      = ($urandom_range(0, 5) == 0);
      MemReqM     = ($urandom_range(0, 3) == 0);
      MemReadyM   = ($urandom_range(0, 9) < 3);
      CntClear    = ($urandom_range(0, 39) == 0);
      #1;
      ec = ref_ctrl();
      n_vec++;
      if (ctrl !== ec) begin n_err++; $display("FAIL rand_ctrl[%0d] got=%b exp=%b", i, ctrl, ec); end
      n_vec++;
      if ({MemErr, StallCount, FlushCount} !== {m_err, 4'(m_sc), 4'(m_fc)}) begin
        n_err++; $display("FAIL rand_regs[%0d] err=%b sc=%0d fc=%0d exp err=%b sc=%0d fc=%0d",
                          i, MemErr, StallCount, FlushCount, m_err, m_sc, m_fc);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
